// File: rtl/onebit_ctrl_pkg.sv
// Shared types and default phase lengths for the one-bit cell sequencer.
package onebit_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_PRE,
    ST_SAMPLE,
    ST_SENSE,
    ST_SMP_SA,
    ST_RECOVER
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  localparam int unsigned T_WR_DEF  = 4;
  localparam int unsigned T_PRE_DEF = 2;
  localparam int unsigned T_SMP_DEF = 2;
  localparam int unsigned T_SA_DEF  = 2;
  localparam int unsigned T_RCV_DEF = 1;

  // Bitcell / sense-amp control bundle, field order is also the bit order.
  typedef struct packed {
    logic preb;
    logic sampleb;
    logic sae;
    logic w_en;
    logic wl;
    logic wlb;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = 6'b010000;

  // Control levels held for the whole duration of a state.
  function automatic ctrl_t ctrl_for(input state_t st, input logic side);
    ctrl_t c;
    c = CTRL_IDLE;
    case (st)
      ST_WRITE:  c = '{preb: 1'b1, sampleb: 1'b1, sae: 1'b0, w_en: 1'b1, wl: 1'b1,  wlb: 1'b1};
      ST_SAMPLE: c = '{preb: 1'b1, sampleb: 1'b0, sae: 1'b0, w_en: 1'b0, wl: !side, wlb: side};
      ST_SENSE:  c = '{preb: 1'b1, sampleb: 1'b1, sae: 1'b1, w_en: 1'b0, wl: 1'b0,  wlb: 1'b0};
      ST_SMP_SA: c = '{preb: 1'b1, sampleb: 1'b0, sae: 1'b1, w_en: 1'b0, wl: !side, wlb: side};
      default:   c = CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counter timing one FSM phase: load a length, flag the final cycle.
module phase_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] len_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load on phase entry, otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = len_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/onebit_seq_ctrl.sv
// Sequencer for one SRAM-style bitcell: write, normal read and fast read.
module onebit_seq_ctrl
  import onebit_ctrl_pkg::*;
#(
  parameter int unsigned T_WR  = T_WR_DEF,
  parameter int unsigned T_PRE = T_PRE_DEF,
  parameter int unsigned T_SMP = T_SMP_DEF,
  parameter int unsigned T_SA  = T_SA_DEF,
  parameter int unsigned T_RCV = T_RCV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_op,
  input  logic req_wdata,
  input  logic req_side,
  input  logic req_fast,
  input  logic sa_out,
  output logic rsp_valid,
  output logic rsp_data,
  output logic done,
  output logic busy,
  output logic preb,
  output logic w_en,
  output logic write_bit,
  output logic sampleb,
  output logic SAE,
  output logic WL,
  output logic WLB
);

  localparam int unsigned M1    = (T_WR > T_PRE) ? T_WR : T_PRE;
  localparam int unsigned M2    = (M1 > T_SMP) ? M1 : T_SMP;
  localparam int unsigned M3    = (M2 > T_SA) ? M2 : T_SA;
  localparam int unsigned T_MAX = (M3 > T_RCV) ? M3 : T_RCV;
  localparam int unsigned CW    = $clog2(T_MAX) + 1;

  state_t        state_q, state_d;
  op_t           op_q;
  logic          side_q, fast_q, wbit_q;
  ctrl_t         ctrl_q, ctrl_d;
  logic          rsp_valid_q, rsp_data_q, done_q, done_d;
  logic          accept, sense_end;
  logic          tmr_load, tmr_last;
  logic [CW-1:0] tmr_len, tmr_cnt;

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;

  phase_timer #(.W(CW)) u_timer (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (tmr_load),
    .len_i  (tmr_len),
    .cnt_o  (tmr_cnt),
    .last_o (tmr_last)
  );

  // Next state and phase-length load; request fields are used directly on acceptance.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_len  = '0;
    case (state_q)
      ST_IDLE: if (accept) begin
        tmr_load = 1'b1;
        if (req_op) begin
          state_d = ST_WRITE;
          tmr_len = CW'(T_WR);
        end else begin
          state_d = ST_PRE;
          tmr_len = CW'(T_PRE);
        end
      end
      ST_WRITE: if (tmr_last) begin
        state_d  = ST_RECOVER;
        tmr_load = 1'b1;
        tmr_len  = CW'(T_RCV);
      end
      ST_PRE: if (tmr_last) begin
        state_d  = fast_q ? ST_SMP_SA : ST_SAMPLE;
        tmr_load = 1'b1;
        tmr_len  = CW'(T_SMP);
      end
      ST_SAMPLE: if (tmr_last) begin
        state_d  = ST_SENSE;
        tmr_load = 1'b1;
        tmr_len  = CW'(T_SA);
      end
      ST_SENSE, ST_SMP_SA: if (tmr_last) begin
        state_d  = ST_RECOVER;
        tmr_load = 1'b1;
        tmr_len  = CW'(T_RCV);
      end
      ST_RECOVER: if (tmr_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Controls are computed from the upcoming state so they switch exactly on entry.
  always_comb begin
    ctrl_d    = ctrl_for(state_d, side_q);
    sense_end = tmr_last && (op_q == OP_READ) &&
                (state_q == ST_SENSE || state_q == ST_SMP_SA);
    // done must land in the last RECOVER cycle: either RECOVER is one cycle long
    // and is being entered, or we are one cycle before its final count.
    done_d = (state_d == ST_RECOVER) &&
             ((state_q != ST_RECOVER) ? (T_RCV == 1) : (tmr_cnt == CW'(2)));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Request latches, registered controls and response/done pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= OP_READ;
      side_q      <= 1'b0;
      fast_q      <= 1'b0;
      wbit_q      <= 1'b0;
      ctrl_q      <= CTRL_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= op_t'(req_op);
        side_q <= req_side;
        fast_q <= req_fast;
        if (req_op) wbit_q <= req_wdata;
      end
      ctrl_q      <= ctrl_d;
      rsp_valid_q <= sense_end;
      if (sense_end) rsp_data_q <= sa_out ^ side_q;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign preb      = ctrl_q.preb;
  assign sampleb   = ctrl_q.sampleb;
  assign SAE       = ctrl_q.sae;
  assign w_en      = ctrl_q.w_en;
  assign WL        = ctrl_q.wl;
  assign WLB       = ctrl_q.wlb;
  assign write_bit = wbit_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign done      = done_q;

endmodule

// File: doc/onebit_seq_ctrl.md
ONEBIT_SEQ_CTRL -- requirements
Module: onebit_seq_ctrl

Interface
REQ-001 Parameters (name, default, meaning), each SHALL be an integer of at least 1:
- T_WR, 4, write phase length in cycles.
- T_PRE, 2, precharge phase length in cycles.
- T_SMP, 2, sample phase length in cycles.
- T_SA, 2, sense-amp phase length in cycles.
- T_RCV, 1, recovery phase length in cycles.
REQ-002 Ports (name, direction, width, meaning). The block SHALL have one clock; reset SHALL be synchronous and active-high.
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- req_valid, in, 1, request offered.
- req_ready, out, 1, request accepted when high together with req_valid.
- req_op, in, 1, 0 = read, 1 = write.
- req_wdata, in, 1, data to write.
- req_side, in, 1, read port: 0 = Q via WL, 1 = QB via WLB.
- req_fast, in, 1, read with merged sample and sense phases.
- sa_out, in, 1, sense-amp result.
- rsp_valid, out, 1, one-cycle pulse marking read data valid.
- rsp_data, out, 1, read data.
- done, out, 1, one-cycle pulse at the end of any operation.
- busy, out, 1, high whenever the FSM is not in IDLE.
- preb, w_en, write_bit, sampleb, SAE, WL, WLB: out, 1 each, bitcell and sense-amp controls.

Function
REQ-003 FSM states SHALL be IDLE, WRITE, PRE, SAMPLE, SENSE, SMP_SA and RECOVER.
REQ-004 req_ready SHALL equal (state==IDLE) and SHALL be driven combinationally.
REQ-005 A request SHALL be accepted on a cycle with req_valid && req_ready. On acceptance, req_op, req_wdata, req_side and req_fast SHALL be latched.
REQ-006 Transitions SHALL follow the operation type:
- Write: IDLE -> WRITE -> RECOVER -> IDLE.
- Normal read: IDLE -> PRE -> SAMPLE -> SENSE -> RECOVER -> IDLE.
- Fast read: IDLE -> PRE -> SMP_SA -> RECOVER -> IDLE.
REQ-007 Each state except IDLE SHALL last exactly its parameter length in cycles. SMP_SA SHALL last T_SMP cycles.
REQ-008 All control outputs SHALL be registered and SHALL change only on a state entry.
REQ-009 Control values per state (preb, sampleb, SAE, w_en, WL, WLB):
- IDLE and RECOVER: 0, 1, 0, 0, 0, 0.
- WRITE: 1, 1, 0, 1, 1, 1.
- PRE: 0, 1, 0, 0, 0, 0.
- SAMPLE: 1, 0, 0, 0, WL = !side, WLB = side.
- SENSE: 1, 1, 1, 0, 0, 0.
- SMP_SA: 1, 0, 1, 0, WL = !side, WLB = side.
REQ-010 write_bit SHALL load req_wdata on entry to WRITE and SHALL hold that value until the next write.
REQ-011 WL or WLB SHALL never be high in a cycle where preb = 0.
REQ-012 sa_out SHALL be sampled in the last cycle of SENSE (or of SMP_SA for a fast read).
- rsp_data SHALL be sa_out XOR side.
- rsp_valid SHALL pulse in the first cycle of RECOVER.
- rsp_data SHALL hold its value until the next read.
REQ-013 done SHALL pulse in the last cycle of RECOVER. The next request SHALL be accepted no earlier than the following cycle.
REQ-014 req_valid while busy SHALL be ignored. The request SHALL not be lost: it remains pending on the interface.

Reset
REQ-015 During rst, the registered outputs SHALL take these values:
- preb = 0, sampleb = 1.
- SAE, w_en, WL, WLB, write_bit, rsp_valid, rsp_data, done = 0.
- state = IDLE, phase counter = 0.
REQ-016 rst asserted in any state SHALL abort the operation. In that case no rsp_valid or done SHALL be produced, and the controls SHALL reach reset values on the next edge.

Structure
REQ-017 Package onebit_ctrl_pkg SHALL hold the state enum, the op encoding and the default T_* constants.
REQ-018 Phase timing SHALL live in sub-module phase_timer:
- load a length, count down, assert a last flag.
- width $clog2(max T)+1.

Verification
REQ-019 Reset then write 1: controls show WRITE values for 4 cycles with write_bit = 1, then 1 RECOVER cycle. done pulses at cycle 5 after acceptance. rsp_valid stays 0.
REQ-020 Normal read, side = 0, sa_out = 1: preb = 0 for 2 cycles, then WL = 1 and sampleb = 0 for 2 cycles, then SAE = 1 for 2 cycles. rsp_valid pulses with rsp_data = 1.
REQ-021 Normal read, side = 1, sa_out = 0: WLB = 1 during SAMPLE and WL = 0 throughout. rsp_data = 1.
REQ-022 Fast read, side = 0: after 2 PRE cycles, WL = 1, sampleb = 0 and SAE = 1 are all high together for 2 cycles. SENSE state is never entered.
REQ-023 rst asserted in the second SAMPLE cycle: the next cycle shows preb = 0, WL = 0 and SAE = 0. No rsp_valid or done pulse occurs, and req_ready = 1 afterwards.
REQ-024 Back-to-back requests held valid: the second is accepted exactly 1 cycle after done. A property check confirms REQ-011 throughout.
